fml_ddr3_arb: RTL and testbench
===============================

# fml_ddr3_arb

Round-robin arbiter that shares the single FML slave port of the DDR3 controller among `N_MASTERS` FML masters, such as CPU instruction/data paths, DMA and video. It sits between the masters and the DDR3 FML front end, on the same `sys_clk` domain. It registers the winning master's request onto the slave port, routes `ack` and read data back, and runs a watchdog that flags slave stalls.

## Interface
Parameters:
- `adr_width`, 30, FML byte address width, matching the DDR3 front end.
- `N_MASTERS`, 4, number of requesters; legal range 2..8.
- `TIMEOUT`, 1024, cycles in BUSY without `s_ack` before `timeout` is raised; legal range 2..65535.

Ports:
- `sys_clk`, in, 1, single clock for the whole block.
- `sys_rst_n`, in, 1, asynchronous active-low reset.
- `m_adr`, in, `N_MASTERS*adr_width`, packed master addresses; master i is at slice i.
- `m_stb`, in, `N_MASTERS`, per-master request.
- `m_we`, in, `N_MASTERS`, per-master write enable.
- `m_sel`, in, `N_MASTERS*8`, per-master byte enables.
- `m_di`, in, `N_MASTERS*64`, per-master write data.
- `m_ack`, out, `N_MASTERS`, per-master acknowledge.
- `m_do`, out, 64, read data, broadcast to all masters.
- `s_adr`, out, `adr_width`, slave address.
- `s_stb`, out, 1, slave request.
- `s_we`, out, 1, slave write enable.
- `s_sel`, out, 8, slave byte enables.
- `s_di`, out, 64, slave write data.
- `s_ack`, in, 1, slave acknowledge.
- `s_do`, in, 64, slave read data.
- `grant`, out, `N_MASTERS`, one-hot owner of the slave port; all zero when IDLE.
- `timeout`, out, 1, sticky watchdog flag.
- `clr_timeout`, in, 1, synchronous clear of `timeout`.

## Operation
- The FML rule applies on both sides. A master holds `stb`, `adr`, `we`, `sel` and `di` stable until it sees `ack`. `ack` is a single-cycle pulse, and read data is valid in the `ack` cycle.
- The state machine has two states, IDLE and BUSY.
- IDLE:
  - If any `m_stb` is high, pick the winner by round robin, starting the search at `last+1` and wrapping modulo `N_MASTERS`.
  - Register the winner's `adr`, `we`, `sel` and `di` into the `s_*` outputs.
  - Set `s_stb`=1, set `grant`=onehot(winner), set `last`=winner, clear the watchdog counter, and go to BUSY.
- BUSY:
  - Hold every `s_*` output and `grant`.
  - `m_ack` = `grant & {N{s_ack}}`, combinational pass-through.
  - When `s_ack`=1, set `s_stb`=0 and `grant`=0 at the next edge and go to IDLE.
- `m_do` = `s_do` at all times, combinational. Masters qualify it with their own `m_ack`.
- If a master drops `m_stb` while BUSY, that is a protocol violation. The arbiter ignores it and keeps `s_stb` high until `s_ack`, because the DDR3 front end cannot abort a request.
- `s_ack` seen in IDLE is spurious. It is ignored, and `m_ack` stays 0.
- Watchdog:
  - A 16-bit counter increments each BUSY cycle without `s_ack`, saturating at `TIMEOUT`.
  - When it reaches `TIMEOUT`, `timeout` is set to 1. The transaction is not aborted.
  - `clr_timeout` clears the flag. If set and clear happen in the same cycle, set wins.
- Reset values: `s_stb`=0, `s_we`=0, `s_adr`=0, `s_sel`=0, `s_di`=0, `grant`=0, `timeout`=0, state IDLE, `last`=`N_MASTERS-1` so that master 0 wins the first arbitration, watchdog counter 0.
- `m_ack` and `m_do` are combinational and follow their sources.
- Reset asserted mid-transaction drops `s_stb` immediately. The DDR3 front end must be reset together with this block; nothing is guaranteed otherwise.

## Timing
- Request to `s_stb`: 1 cycle. If `m_stb` is seen high at edge k in IDLE, `s_stb` is high after edge k.
- `s_ack` to `m_ack`: 0 cycles.
- Gap between transactions: `s_stb` is low for at least 1 cycle after each `s_ack`. This is the IDLE cycle in which masters have already removed or renewed `stb`.
- Best-case throughput: one transaction every (slave latency + 1) cycles.
- Fairness: a continuously requesting master waits at most `N_MASTERS-1` transactions.

## Structure
- Package `fml_arb_pkg` holds:
  - The state enum (IDLE, BUSY).
  - The constants `FML_DW`=64 and `FML_SW`=8.
  - The watchdog width, 16.
- Sub-module `fml_rr_pick` is combinational:
  - Inputs: `req[N]`, `last`.
  - Outputs: `valid`, `idx`.
  - It is instantiated once, so the round-robin search can be verified on its own.

## Test plan
- Single master: master 2 requests a read at `adr`=0x100, and the slave acks 5 cycles after `s_stb`. Expect `s_stb` one cycle after the request, `s_adr`=0x100, `m_ack`=4'b0100 for one cycle, and `m_do`=`s_do` in that cycle.
- All four masters request continuously after reset, with the slave acking after 3 cycles. Expect grant order 0,1,2,3,0, with exactly one `s_stb`-low cycle between transactions.
- Write path: master 1 has `we`=1, `sel`=0x0F and `di`=0xDEADBEEF_CAFEF00D. Expect the `s_*` outputs to match exactly and stay stable until `s_ack`.
- Watchdog with `TIMEOUT`=8: the slave never acks. Expect `timeout`=1 after 8 BUSY cycles, with `s_stb` still 1. Then `s_ack` arrives, and after that `clr_timeout` clears the flag.
- Master 0 drops `m_stb` while BUSY. Expect `s_stb` to stay 1 until `s_ack`. A spurious `s_ack` in IDLE produces no `m_ack`.
- Assert `sys_rst_n` low mid-BUSY. Expect all registered outputs at their reset values immediately, and master 0 to win the next arbitration.

Source files
------------

// File: rtl/fml_arb_pkg.sv
// Shared definitions for the FML DDR3 arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   FML_DW      : FML data width in bits
//   FML_SW      : FML byte-select width
//   WD_W        : watchdog counter width
package fml_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int FML_DW = 64;
  localparam int FML_SW = 8;
  localparam int WD_W   = 16;

endpackage

// File: rtl/fml_rr_pick.sv
// Combinational round-robin picker.
//   req   : per-requester request vector
//   last  : index of the previous winner; search starts at last+1
//   valid : at least one request is present
//   idx   : index of the winner (0 when valid is low)
module fml_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int cand;

  // Walk offsets 1..N from last; the first requester found wins, which
  // puts last itself at the lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last) + off) % N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fml_ddr3_arb.sv
// Round-robin arbiter sharing one FML slave port among N_MASTERS masters.
//   sys_clk, sys_rst_n     : clock, asynchronous active-low reset
//   m_adr/m_stb/m_we/m_sel/m_di : packed master requests (master i at slice i)
//   m_ack                  : per-master ack (grant gated by s_ack)
//   m_do                   : read data broadcast, equal to s_do
//   s_adr/s_stb/s_we/s_sel/s_di : registered request toward the DDR3 front end
//   s_ack, s_do            : slave acknowledge and read data
//   grant                  : one-hot owner of the slave port, zero when idle
//   timeout, clr_timeout   : sticky watchdog flag and its synchronous clear
//   dbg_state              : current arbiter FSM state
//
// Handshake: FML on both sides. A request (stb plus adr/we/sel/di) is held
// stable until ack; ack is a one-cycle pulse and read data is valid with it.
// Once a request is forwarded, s_stb stays high until s_ack regardless of
// what the owning master does, since the slave cannot abort a request.
module fml_ddr3_arb
  import fml_arb_pkg::*;
#(
  parameter int adr_width = 30,
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [N_MASTERS*adr_width-1:0]  m_adr,
  input  logic [N_MASTERS-1:0]            m_stb,
  input  logic [N_MASTERS-1:0]            m_we,
  input  logic [N_MASTERS*FML_SW-1:0]     m_sel,
  input  logic [N_MASTERS*FML_DW-1:0]     m_di,
  output logic [N_MASTERS-1:0]            m_ack,
  output logic [FML_DW-1:0]               m_do,
  output logic [adr_width-1:0]            s_adr,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [FML_SW-1:0]               s_sel,
  output logic [FML_DW-1:0]               s_di,
  input  logic                            s_ack,
  input  logic [FML_DW-1:0]               s_do,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            timeout,
  input  logic                            clr_timeout,
  output arb_state_t                      dbg_state
);

  localparam int IW = $clog2(N_MASTERS);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  arb_state_t          state;
  logic [IW-1:0]       last;
  logic [WD_W-1:0]     wd_cnt;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;

  logic [adr_width-1:0] win_adr;
  logic                 win_we;
  logic [FML_SW-1:0]    win_sel;
  logic [FML_DW-1:0]    win_di;

  fml_rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (m_stb),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the winner's request fields from the packed master buses.
  always_comb begin
    win_adr = '0;
    win_we  = 1'b0;
    win_sel = '0;
    win_di  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (IW'(i) == pick_idx) begin
        win_adr = m_adr[i*adr_width +: adr_width];
        win_we  = m_we[i];
        win_sel = m_sel[i*FML_SW +: FML_SW];
        win_di  = m_di[i*FML_DW +: FML_DW];
      end
    end
  end

  // grant is zero outside BUSY, so a spurious s_ack in IDLE never reaches
  // a master; the state term keeps that true even if grant were disturbed.
  assign m_ack     = (state == BUSY) ? (grant & {N_MASTERS{s_ack}}) : '0;
  assign m_do      = s_do;
  assign dbg_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      last    <= IW'(N_MASTERS - 1);
      wd_cnt  <= '0;
      timeout <= 1'b0;
      s_adr   <= '0;
      s_stb   <= 1'b0;
      s_we    <= 1'b0;
      s_sel   <= '0;
      s_di    <= '0;
      grant   <= '0;
    end else begin
      // Clear first so that a watchdog set in the same cycle overrides it.
      if (clr_timeout) timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            s_adr  <= win_adr;
            s_we   <= win_we;
            s_sel  <= win_sel;
            s_di   <= win_di;
            s_stb  <= 1'b1;
            grant  <= N_MASTERS'(1) << pick_idx;
            last   <= pick_idx;
            wd_cnt <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack) begin
            s_stb <= 1'b0;
            grant <= '0;
            state <= IDLE;
          end else if (wd_cnt != WD_MAX) begin
            // Saturating count of stalled cycles; the flag is raised on the
            // step that reaches WD_MAX, and the transfer keeps waiting.
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_MAX - 1'b1) timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fml_ddr3_arb.sv
// Directed bench for fml_ddr3_arb (4 masters, 30-bit addresses, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fml_ddr3_arb;
  import fml_arb_pkg::*;

  localparam int AW = 30;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [N*AW-1:0]   m_adr;
  logic [N-1:0]      m_stb;
  logic [N-1:0]      m_we;
  logic [N*8-1:0]    m_sel;
  logic [N*64-1:0]   m_di;
  logic [N-1:0]      m_ack;
  logic [63:0]       m_do;
  logic [AW-1:0]     s_adr;
  logic              s_stb;
  logic              s_we;
  logic [7:0]        s_sel;
  logic [63:0]       s_di;
  logic              s_ack;
  logic [63:0]       s_do;
  logic [N-1:0]      grant;
  logic              timeout;
  logic              clr_timeout;
  arb_state_t        dbg_state;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [3:0] exp_q[$];

  fml_ddr3_arb #(.adr_width(AW), .N_MASTERS(N), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_di(m_di),
    .m_ack(m_ack), .m_do(m_do),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_di(s_di),
    .s_ack(s_ack), .s_do(s_do),
    .grant(grant), .timeout(timeout), .clr_timeout(clr_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_master(input int i, input logic stb, input logic [AW-1:0] adr,
                            input logic we, input logic [7:0] sel, input logic [63:0] di);
    m_stb[i]           = stb;
    m_adr[i*AW +: AW]  = adr;
    m_we[i]            = we;
    m_sel[i*8 +: 8]    = sel;
    m_di[i*64 +: 64]   = di;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  // Pulse s_ack for one cycle, checking the combinational return path,
  // then confirm the arbiter is back in its idle gap cycle.
  task automatic slave_ack(input logic [63:0] data, input logic [3:0] exp_ack);
    s_do  = data;
    s_ack = 1'b1;
    #1;
    check("m_ack", 64'(m_ack), 64'(exp_ack));
    check("m_do", m_do, data);
    tick();
    s_ack = 1'b0;
    check("gap_s_stb", 64'(s_stb), 64'd0);
    check("gap_grant", 64'(grant), 64'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [3:0] exp_g;
    sys_rst_n   = 1'b0;
    m_adr       = '0;
    m_stb       = '0;
    m_we        = '0;
    m_sel       = '0;
    m_di        = '0;
    s_ack       = 1'b0;
    s_do        = '0;
    clr_timeout = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_s_stb", 64'(s_stb), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_adr", 64'(s_adr), 64'd0);
    check("rst_s_sel", 64'(s_sel), 64'd0);
    check("rst_s_di", s_di, 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    sys_rst_n = 1'b1;
    tick();

    // Single master read: master 2, adr 0x100, ack 5 cycles after s_stb
    set_master(2, 1'b1, 30'h100, 1'b0, 8'hFF, 64'd0);
    tick();
    check("t1_s_stb", 64'(s_stb), 64'd1);
    check("t1_s_adr", 64'(s_adr), 64'h100);
    check("t1_grant", 64'(grant), 64'b0100);
    check("t1_state", 64'(dbg_state), 64'(BUSY));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t1_hold_stb", 64'(s_stb), 64'd1);
      check("t1_no_ack", 64'(m_ack), 64'd0);
    end
    slave_ack(64'h1122_3344_5566_7788, 4'b0100);
    set_master(2, 1'b0, '0, 1'b0, 8'h00, 64'd0);

    // All four masters continuously, slave latency 3: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_master(i, 1'b1, AW'(30'h200 + i), 1'b0, 8'hFF, 64'd0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int t = 0; t < 5; t++) begin
      tick();
      exp_g = exp_q.pop_front();
      check("rr_s_stb", 64'(s_stb), 64'd1);
      check("rr_grant", 64'(grant), 64'(exp_g));
      check("rr_s_adr", 64'(s_adr), 64'(30'h200 + $clog2(exp_g)));
      tick();
      tick();
      slave_ack(64'(t), exp_g);
    end
    m_stb = '0;
    tick();

    // Write path: master 1, stable until ack
    set_master(1, 1'b1, 30'h3A5, 1'b1, 8'h0F, 64'hDEADBEEF_CAFEF00D);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("wr_s_we", 64'(s_we), 64'd1);
      check("wr_s_sel", 64'(s_sel), 64'h0F);
      check("wr_s_di", s_di, 64'hDEADBEEF_CAFEF00D);
      check("wr_s_adr", 64'(s_adr), 64'h3A5);
      check("wr_grant", 64'(grant), 64'b0010);
    end
    slave_ack(64'd0, 4'b0010);
    set_master(1, 1'b0, '0, 1'b0, 8'h00, 64'd0);
    tick();

    // Watchdog: master 3 read, slave silent; flag after 8 BUSY cycles
    set_master(3, 1'b1, 30'h040, 1'b0, 8'hFF, 64'd0);
    tick();
    check("wd_s_stb", 64'(s_stb), 64'd1);
    for (int c = 0; c < 7; c++) tick();
    check("wd_not_yet", 64'(timeout), 64'd0);
    clr_timeout = 1'b1;  // same edge as the set: set must win
    tick();
    clr_timeout = 1'b0;
    check("wd_set_wins", 64'(timeout), 64'd1);
    check("wd_stb_held", 64'(s_stb), 64'd1);
    tick();
    tick();
    check("wd_sticky", 64'(timeout), 64'd1);
    slave_ack(64'hA5A5_A5A5_0000_FFFF, 4'b1000);
    set_master(3, 1'b0, '0, 1'b0, 8'h00, 64'd0);
    check("wd_after_ack", 64'(timeout), 64'd1);
    clr_timeout = 1'b1;
    tick();
    clr_timeout = 1'b0;
    check("wd_cleared", 64'(timeout), 64'd0);

    // Master 0 drops stb while BUSY; s_stb held until s_ack
    set_master(0, 1'b1, 30'h7, 1'b0, 8'hFF, 64'd0);
    tick();
    check("drop_s_stb", 64'(s_stb), 64'd1);
    m_stb[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("drop_hold", 64'(s_stb), 64'd1);
      check("drop_grant", 64'(grant), 64'b0001);
    end
    slave_ack(64'h55, 4'b0001);

    // Spurious s_ack in IDLE
    s_ack = 1'b1;
    #1;
    check("spur_m_ack", 64'(m_ack), 64'd0);
    tick();
    s_ack = 1'b0;
    check("spur_s_stb", 64'(s_stb), 64'd0);
    check("spur_state", 64'(dbg_state), 64'(IDLE));

    // Reset mid-BUSY: master 1 write in flight, then masters 0 and 3 compete
    set_master(1, 1'b1, 30'h155, 1'b1, 8'hC3, 64'h0123_4567_89AB_CDEF);
    tick();
    check("mid_busy", 64'(s_stb), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_s_stb", 64'(s_stb), 64'd0);
    check("mid_grant", 64'(grant), 64'd0);
    check("mid_s_we", 64'(s_we), 64'd0);
    check("mid_s_adr", 64'(s_adr), 64'd0);
    check("mid_s_sel", 64'(s_sel), 64'd0);
    check("mid_s_di", s_di, 64'd0);
    m_stb = '0;
    set_master(0, 1'b1, 30'h10, 1'b0, 8'hFF, 64'd0);
    set_master(3, 1'b1, 30'h13, 1'b0, 8'hFF, 64'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    check("post_rst_grant", 64'(grant), 64'b0001);
    check("post_rst_adr", 64'(s_adr), 64'h10);
    slave_ack(64'h99, 4'b0001);
    m_stb = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
